// File: rtl/mem_dump_unit_if.sv
// Memory-read and UART-tx handshake bundle between mem_dump_unit (master) and its
// surroundings (slave: Data_Memory read port plus UART transmitter).
`timescale 1ns/1ps
interface mem_dump_unit_if #(
    parameter int AB = 11,
    parameter int DB = 16
);
    logic          RdRam;
    logic [AB-1:0] Addr;
    logic [DB-1:0] Mem_Data;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_done;

    modport master (
        output RdRam, Addr, tx_data, tx_start,
        input  Mem_Data, tx_done
    );

    modport slave (
        input  RdRam, Addr, tx_data, tx_start,
        output Mem_Data, tx_done
    );
endinterface

// File: rtl/mem_dump_unit.sv
// Walks data memory 0..DEPTH-1 and streams each word MSB-byte-first to a UART transmitter.
// Define MEM_DUMP_CHECKSUM_EN to append an 8-bit XOR of all data bytes after the last word.
`timescale 1ns/1ps
module mem_dump_unit #(
    parameter int AB    = 11,
    parameter int DB    = 16,
    parameter int DEPTH = 101
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    mem_dump_unit_if.master bus,
    output logic            busy,
    output logic            done
);
    localparam int NB = DB / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [AB-1:0] LAST_ADDR = AB'(DEPTH - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NB - 1);

`ifdef MEM_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_CSUM, S_FIN} state_e;
    logic [7:0]    xor_q;
`else
    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_FIN} state_e;
`endif

    state_e        state_q;
    logic          rd_ram_q;
    logic [AB-1:0] addr_q;
    logic [DB-1:0] word_q;
    logic [7:0]    tx_data_q;
    logic          tx_start_q;
    logic [IW-1:0] idx_q;
    logic          busy_q;
    logic          done_q;

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rd_ram_q   <= 1'b0;
            addr_q     <= '0;
            word_q     <= '0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
            xor_q      <= 8'h00;
`endif
        end else begin
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q   <= '0;
                        rd_ram_q <= 1'b1;
                        busy_q   <= 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
                        xor_q    <= 8'h00;
`endif
                        state_q  <= S_READ;
                    end
                end
                S_READ: begin
                    rd_ram_q   <= 1'b0;
                    word_q     <= bus.Mem_Data << 8;
                    tx_data_q  <= bus.Mem_Data[DB-1 -: 8];
                    tx_start_q <= 1'b1;
                    idx_q      <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
                    xor_q      <= xor_q ^ bus.Mem_Data[DB-1 -: 8];
`endif
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    // A tx_done coinciding with our own tx_start belongs to no launched byte.
                    if (bus.tx_done && !tx_start_q) begin
                        if (idx_q != LAST_IDX) begin
                            idx_q      <= idx_q + 1'b1;
                            tx_data_q  <= word_q[DB-1 -: 8];
                            word_q     <= word_q << 8;
                            tx_start_q <= 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
                            xor_q      <= xor_q ^ word_q[DB-1 -: 8];
`endif
                        end else if (addr_q != LAST_ADDR) begin
                            addr_q   <= addr_q + 1'b1;
                            rd_ram_q <= 1'b1;
                            state_q  <= S_READ;
                        end else begin
`ifdef MEM_DUMP_CHECKSUM_EN
                            tx_data_q  <= xor_q;
                            tx_start_q <= 1'b1;
                            state_q    <= S_CSUM;
`else
                            state_q    <= S_FIN;
`endif
                        end
                    end
                end
`ifdef MEM_DUMP_CHECKSUM_EN
                S_CSUM: begin
                    if (bus.tx_done && !tx_start_q) state_q <= S_FIN;
                end
`endif
                S_FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    addr_q  <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.RdRam    = rd_ram_q;
    assign bus.Addr     = addr_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_start = tx_start_q;
    assign busy         = busy_q;
    assign done         = done_q;
endmodule

// File: tb/tb_mem_dump_unit.sv
// Directed bench for mem_dump_unit: DEPTH=9 and DEPTH=1 instances, memory and UART responder models.
`timescale 1ns/1ps
module tb_mem_dump_unit;
    localparam int AB = 11;
    localparam int DB = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic start_a, start_b, busy_a, busy_b, done_a, done_b;

    mem_dump_unit_if #(.AB(AB), .DB(DB)) if_a ();
    mem_dump_unit_if #(.AB(AB), .DB(DB)) if_b ();

    mem_dump_unit #(.AB(AB), .DB(DB), .DEPTH(9)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .bus(if_a), .busy(busy_a), .done(done_a));
    mem_dump_unit #(.AB(AB), .DB(DB), .DEPTH(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .bus(if_b), .busy(busy_b), .done(done_b));

    int checks = 0;
    int errors = 0;

    // Memory model: Out_Data loads on the negedge while RdRam is high.
    logic [DB-1:0] mem [0:8];
    always @(negedge clk) begin
        if (if_a.RdRam) if_a.Mem_Data <= mem[if_a.Addr];
        if (if_b.RdRam) if_b.Mem_Data <= mem[if_b.Addr];
    end

    // UART responder and monitor, steered to one DUT by sel.
    logic sel = 1'b0;
    logic force_done = 1'b0;
    logic resp_done = 1'b0;
    int   delay = 10;
    bit   early = 1'b0;
    int   cnt = 0;
    int   overlap = 0;
    int   rd_double = 0;
    logic rd_prev = 1'b0;
    logic [7:0]    bytes_q[$];
    logic [AB-1:0] rd_addrs[$];
    logic [7:0]    exp_q[$];

    logic          m_tx_start, m_rd;
    logic [7:0]    m_tx_data;
    logic [AB-1:0] m_addr;
    assign m_tx_start   = sel ? if_b.tx_start : if_a.tx_start;
    assign m_tx_data    = sel ? if_b.tx_data  : if_a.tx_data;
    assign m_rd         = sel ? if_b.RdRam    : if_a.RdRam;
    assign m_addr       = sel ? if_b.Addr     : if_a.Addr;
    assign if_a.tx_done = !sel && (resp_done || force_done);
    assign if_b.tx_done =  sel && (resp_done || force_done);

    always @(negedge clk) begin
        resp_done <= 1'b0;
        if (!rst_n) begin
            cnt     <= 0;
            rd_prev <= 1'b0;
        end else begin
            if (m_tx_start) begin
                bytes_q.push_back(m_tx_data);
                if (cnt != 0) overlap <= overlap + 1;
                cnt <= delay;
                if (early) resp_done <= 1'b1;
            end else if (cnt == 1) begin
                resp_done <= 1'b1;
                cnt       <= 0;
            end else if (cnt > 1) begin
                cnt <= cnt - 1;
            end
            if (m_rd) begin
                rd_addrs.push_back(m_addr);
                if (rd_prev) rd_double <= rd_double + 1;
            end
            rd_prev <= m_rd;
        end
    end

    task automatic fill_exp(input int depth);
        logic [7:0] x;
        x = 8'h00;
        exp_q.delete();
        for (int i = 0; i < depth; i++) begin
            exp_q.push_back(mem[i][15:8]);
            exp_q.push_back(mem[i][7:0]);
            x = x ^ mem[i][15:8] ^ mem[i][7:0];
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic pulse_start(input bit use_b);
        @(negedge clk);
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input bit use_b, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((use_b ? done_b : done_a) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({if_a.RdRam, if_a.tx_start, busy_a, done_a} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl_a: got %b expected 0000", {if_a.RdRam, if_a.tx_start, busy_a, done_a});
        end
        checks++;
        if ({if_a.Addr, if_a.tx_data} !== '0) begin
            errors++; $display("FAIL reset_data_a: addr %h data %h expected 0", if_a.Addr, if_a.tx_data);
        end
        checks++;
        if ({if_b.RdRam, if_b.tx_start, busy_b, done_b, if_b.Addr, if_b.tx_data} !== '0) begin
            errors++; $display("FAIL reset_b: outputs not all zero");
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_dump();
        int b0, r0, ov0, rd0;
        bit ok;
        fill_exp(9);
        b0 = bytes_q.size(); r0 = rd_addrs.size(); ov0 = overlap; rd0 = rd_double;
        pulse_start(1'b0);
        checks++;
        if (busy_a !== 1'b1) begin errors++; $display("FAIL dump_busy: got %b expected 1", busy_a); end
        wait_done(1'b0, 3000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL dump_timeout: done not seen within 3000 cycles"); end
        checks++;
        if (busy_a !== 1'b0 || if_a.Addr !== '0) begin
            errors++; $display("FAIL dump_end: busy %b addr %0d expected 0/0", busy_a, if_a.Addr);
        end
        checks++;
        if (bytes_q.size() - b0 != exp_q.size()) begin
            errors++; $display("FAIL dump_count: got %0d bytes expected %0d", bytes_q.size() - b0, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (bytes_q[b0+i] !== exp_q[i]) begin
                    errors++; $display("FAIL dump_byte%0d: got %h expected %h", i, bytes_q[b0+i], exp_q[i]);
                end
            end
        end
        checks++;
        if (rd_addrs.size() - r0 != 9) begin
            errors++; $display("FAIL read_count: got %0d expected 9", rd_addrs.size() - r0);
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (rd_addrs[r0+i] !== AB'(i)) begin
                    errors++; $display("FAIL read_addr%0d: got %0d expected %0d", i, rd_addrs[r0+i], i);
                end
            end
        end
        checks++;
        if (rd_double != rd0 || overlap != ov0) begin
            errors++; $display("FAIL handshake: rdram_double %0d overlap %0d expected 0/0", rd_double - rd0, overlap - ov0);
        end
        @(negedge clk);
        checks++;
        if (done_a !== 1'b0) begin errors++; $display("FAIL done_width: got %b expected 0", done_a); end
    endtask

    task automatic test_ignored();
        int b0, b1, r0;
        bit ok;
        fill_exp(9);
        b0 = bytes_q.size(); r0 = rd_addrs.size();
        pulse_start(1'b0);
        repeat (40) @(negedge clk);
        pulse_start(1'b0);
        repeat (60) @(negedge clk);
        pulse_start(1'b0);
        wait_done(1'b0, 3000, ok);
        checks++;
        if (!ok || bytes_q.size() - b0 != exp_q.size() || rd_addrs.size() - r0 != 9) begin
            errors++; $display("FAIL ignore_start: ok %0d bytes %0d reads %0d expected 1/%0d/9",
                               ok, bytes_q.size() - b0, rd_addrs.size() - r0, exp_q.size());
        end
        b1 = bytes_q.size();
        repeat (3) begin
            @(negedge clk); force_done = 1'b1;
            @(negedge clk); force_done = 1'b0;
            repeat (3) @(negedge clk);
        end
        checks++;
        if (bytes_q.size() != b1 || busy_a !== 1'b0 || if_a.RdRam !== 1'b0 || if_a.Addr !== '0) begin
            errors++; $display("FAIL ignore_txdone: bytes %0d busy %b rdram %b addr %0d expected 0/0/0/0",
                               bytes_q.size() - b1, busy_a, if_a.RdRam, if_a.Addr);
        end
    endtask

    task automatic test_async_reset();
        int b0, r0, ov0;
        bit ok, hit;
        fill_exp(9);
        b0 = bytes_q.size();
        pulse_start(1'b0);
        hit = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk); #1;
            if (bytes_q.size() - b0 == 5) begin hit = 1'b1; break; end
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL areset_wait: 5th byte not seen within 1000 cycles"); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({if_a.RdRam, if_a.tx_start, busy_a, done_a, if_a.Addr, if_a.tx_data} !== '0) begin
            errors++; $display("FAIL areset_outputs: rdram %b txs %b busy %b done %b addr %0d data %h expected 0",
                               if_a.RdRam, if_a.tx_start, busy_a, done_a, if_a.Addr, if_a.tx_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        b0 = bytes_q.size(); r0 = rd_addrs.size(); ov0 = overlap;
        pulse_start(1'b0);
        wait_done(1'b0, 3000, ok);
        checks++;
        if (!ok || bytes_q.size() - b0 != exp_q.size() || rd_addrs.size() - r0 != 9 || overlap != ov0) begin
            errors++; $display("FAIL areset_restart: ok %0d bytes %0d reads %0d overlap %0d expected 1/%0d/9/0",
                               ok, bytes_q.size() - b0, rd_addrs.size() - r0, overlap - ov0, exp_q.size());
        end else begin
            checks++;
            if (rd_addrs[r0] !== '0) begin errors++; $display("FAIL areset_addr0: got %0d expected 0", rd_addrs[r0]); end
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (bytes_q[b0+i] !== exp_q[i]) begin
                    errors++; $display("FAIL areset_byte%0d: got %h expected %h", i, bytes_q[b0+i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_depth1();
        int b0, r0, ov0;
        bit ok;
        sel = 1'b1; early = 1'b1; delay = 3;
        mem[0] = 16'hA55A;
        fill_exp(1);
        b0 = bytes_q.size(); r0 = rd_addrs.size(); ov0 = overlap;
        pulse_start(1'b1);
        wait_done(1'b1, 500, ok);
        checks++;
        if (!ok || busy_b !== 1'b0 || if_b.Addr !== '0) begin
            errors++; $display("FAIL depth1_done: ok %0d busy %b addr %0d expected 1/0/0", ok, busy_b, if_b.Addr);
        end
        checks++;
        if (overlap != ov0 || rd_addrs.size() - r0 != 1) begin
            errors++; $display("FAIL depth1_handshake: overlap %0d reads %0d expected 0/1", overlap - ov0, rd_addrs.size() - r0);
        end
        checks++;
        if (bytes_q.size() - b0 != exp_q.size()) begin
            errors++; $display("FAIL depth1_count: got %0d expected %0d", bytes_q.size() - b0, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (bytes_q[b0+i] !== exp_q[i]) begin
                    errors++; $display("FAIL depth1_byte%0d: got %h expected %h", i, bytes_q[b0+i], exp_q[i]);
                end
            end
        end
        early = 1'b0; delay = 10;
    endtask

    initial begin
        start_a = 1'b0;
        start_b = 1'b0;
        for (int i = 0; i < 9; i++) mem[i] = '0;
        mem[4] = 16'h3FC0;
        test_reset();
        test_dump();
        test_ignored();
        test_async_reset();
        test_depth1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
